muldiv_ctrl: RTL and testbench

- Multicycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS datapath.
- Replaces the single-cycle HI/LO multiply path with an iterative 32-step engine: radix-2 shift-add multiply and restoring divide.
- Sits beside the ALU.
- The control unit issues operations through a start/busy/done handshake and stalls the pipeline when HI/LO accesses collide with an in-flight operation.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_iter.sv | 25 ++
 rtl/muldiv_ctrl.sv | 91 +++++++++
 tb/tb_muldiv_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM state codes and default width for the HI/LO multiply/divide sequencer
package muldiv_pkg;
  localparam int WIDTH = 32;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FIN    = 2'd2;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational radix-2 step of shift-add multiply or restoring divide
// Ports: i_div selects divide; i_acc/i_aux are the upper/lower working halves (product high/multiplier,
// or remainder/quotient); i_opnd is the multiplicand or divisor; o_acc/o_aux are the next halves.
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         i_div,
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_aux,
  input  logic [W-1:0] i_opnd,
  output logic [W-1:0] o_acc,
  output logic [W-1:0] o_aux
);
  logic [W:0]   w_sum;
  logic [W:0]   w_sh;
  logic [W-1:0] w_dif;
  logic         w_ge;
  assign w_sum = {1'b0, i_acc} + {1'b0, (i_aux[0] ? i_opnd : {W{1'b0}})};
  // Shifted remainder needs W+1 bits; the difference always fits W bits when the trial succeeds.
  assign w_sh  = {i_acc, i_aux[W-1]};
  assign w_ge  = w_sh >= {1'b0, i_opnd};
  assign w_dif = w_sh[W-1:0] - i_opnd;
  assign o_acc = i_div ? (w_ge ? w_dif : w_sh[W-1:0]) : w_sum[W:1];
  assign o_aux = i_div ? {i_aux[W-2:0], w_ge} : {w_sum[0], i_aux[W-1:1]};
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer owning the HI/LO register pair
// Ports: i_start/i_op request an op with operands i_a (rs) and i_b (rt); i_mf_req flags an MFHI/MFLO read;
// o_hi/o_lo are the HI/LO registers; o_busy marks an op in flight; o_done pulses after a result write;
// o_stall holds the pipeline when a HI/LO access collides with an in-flight op.
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int WIDTH = muldiv_pkg::WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mf_req,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall
);
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc, r_aux, r_opnd, r_hi, r_lo;
  logic               r_div, r_sq, r_sr, r_done;
  logic [WIDTH-1:0]   w_nacc, w_naux, w_ma, w_mb;
  logic [2*WIDTH-1:0] w_prod, w_res;
  logic               w_sgn, w_md, w_div, w_valid;
  assign w_md    = ~i_op[2];
  assign w_div   = i_op[1];
  assign w_sgn   = ~i_op[0];
  assign w_valid = i_op <= OP_MTLO;
  assign w_ma    = (w_sgn & i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mb    = (w_sgn & i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_prod  = r_sq ? -{r_acc, r_aux} : {r_acc, r_aux};
  assign w_res   = r_div ? {(r_sr ? -r_acc : r_acc), (r_sq ? -r_aux : r_aux)} : w_prod;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = r_state != S_IDLE;
  assign o_done  = r_done;
  assign o_stall = o_busy & (i_mf_req | (i_start & w_valid));
  muldiv_iter #(.W(WIDTH)) u_iter (
    .i_div  (r_div),
    .i_acc  (r_acc),
    .i_aux  (r_aux),
    .i_opnd (r_opnd),
    .o_acc  (w_nacc),
    .o_aux  (w_naux)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_aux   <= '0;
      r_opnd  <= '0;
      r_div   <= 1'b0;
      r_sq    <= 1'b0;
      r_sr    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= r_state == S_FIN;
      if (r_state == S_IDLE) begin
        if (i_start && w_md) begin
          r_state <= S_CALC;
          r_cnt   <= '0;
          r_acc   <= '0;
          r_aux   <= w_div ? w_ma : w_mb;
          r_opnd  <= w_div ? w_mb : w_ma;
          r_div   <= w_div;
          r_sq    <= w_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
          r_sr    <= w_sgn & i_a[WIDTH-1];
        end else if (i_start && i_op == OP_MTHI) begin
          r_hi <= i_a;
        end else if (i_start && i_op == OP_MTLO) begin
          r_lo <= i_a;
        end
      end else if (r_state == S_CALC) begin
        r_acc <= w_nacc;
        r_aux <= w_naux;
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIN;
      end else begin
        {r_hi, r_lo} <= w_res;
        r_state      <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
  logic        clk, rst_n, i_start, i_mf_req;
  logic [2:0]  i_op;
  logic [31:0] i_a, i_b, o_hi, o_lo;
  logic        o_busy, o_done, o_stall;
  int          n_chk = 0;
  int          n_err = 0;
  muldiv_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_mf_req (i_mf_req),
    .o_hi     (o_hi),
    .o_lo     (o_lo),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_stall  (o_stall)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_start = 1'b1;
    i_op = op;
    i_a = a;
    i_b = b;
    #1;
    chk("stall_idle_start", {31'd0, o_stall}, 32'd0);
    step();
    i_start = 1'b0;
    i_a = 32'h5555_AAAA;
    i_b = 32'hAAAA_5555;
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] h0, l0;
    int n;
    logic chg;
    h0 = o_hi;
    l0 = o_lo;
    issue(op, a, b);
    chk({tag, "_busy_e0"}, {31'd0, o_busy}, 32'd1);
    n = 0;
    chg = 1'b0;
    while (o_busy && n < 40) begin
      step();
      n++;
      if (o_busy && (o_hi !== h0 || o_lo !== l0)) chg = 1'b1;
    end
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_hilo_stable"}, {31'd0, chg}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd1);
    chk({tag, "_hi"}, o_hi, ehi);
    chk({tag, "_lo"}, o_lo, elo);
    step();
    chk({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic bad;
    int n;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_op = 3'd0;
    i_a = '0;
    i_b = '0;
    i_mf_req = 1'b0;
    #12;
    chk("rst_hi", o_hi, 32'd0);
    chk("rst_lo", o_lo, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    rst_n = 1'b1;
    step();
    run("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_zero", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run("div_zero_neg", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1);
    run("div_zero_pos", 3'd2, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run("divu_1000_7", 3'd3, 32'd1000, 32'd7, 32'd6, 32'd142);
    run("div_pos_neg", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    issue(3'd0, 32'h0000_1234, 32'h0000_0010);
    repeat (4) step();
    i_mf_req = 1'b1;
    bad = 1'b0;
    n = 0;
    while (o_busy && n < 40) begin
      if (n == 5) begin
        i_start = 1'b1;
        i_op = 3'd1;
        i_a = 32'h0000_FFFF;
        i_b = 32'h0000_FFFF;
      end
      #1;
      if (!o_stall) bad = 1'b1;
      step();
      i_start = 1'b0;
      n++;
    end
    chk("mf_stall_in_flight", {31'd0, bad}, 32'd0);
    chk("mf_done", {31'd0, o_done}, 32'd1);
    chk("mf_done_stall", {31'd0, o_stall}, 32'd0);
    chk("mf_hi", o_hi, 32'd0);
    chk("mf_lo", o_lo, 32'h0001_2340);
    i_mf_req = 1'b0;
    step();
    chk("mf_no_restart", {31'd0, o_busy}, 32'd0);
    i_start = 1'b1;
    i_op = 3'd4;
    i_a = 32'h1234_5678;
    #1;
    chk("mthi_stall", {31'd0, o_stall}, 32'd0);
    step();
    chk("mthi_hi", o_hi, 32'h1234_5678);
    chk("mthi_lo_keep", o_lo, 32'h0001_2340);
    chk("mthi_busy", {31'd0, o_busy}, 32'd0);
    chk("mthi_done", {31'd0, o_done}, 32'd0);
    i_op = 3'd5;
    i_a = 32'h9ABC_DEF0;
    step();
    chk("mtlo_lo", o_lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_keep", o_hi, 32'h1234_5678);
    chk("mtlo_busy", {31'd0, o_busy}, 32'd0);
    chk("mtlo_done", {31'd0, o_done}, 32'd0);
    i_op = 3'd6;
    i_a = 32'hDEAD_BEEF;
    #1;
    chk("badop_stall", {31'd0, o_stall}, 32'd0);
    step();
    chk("badop_busy", {31'd0, o_busy}, 32'd0);
    chk("badop_hi", o_hi, 32'h1234_5678);
    chk("badop_lo", o_lo, 32'h9ABC_DEF0);
    i_start = 1'b0;
    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) step();
    chk("abort_busy_pre", {31'd0, o_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_hi", o_hi, 32'd0);
    chk("abort_lo", o_lo, 32'd0);
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    chk("abort_stay_idle", {31'd0, o_busy}, 32'd0);
    chk("abort_no_result", o_lo, 32'd0);
    run("mult_6x7", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
